// File: rtl/ddr_4ch_arbiter.sv
// Round-robin arbiter sharing one DDR command port between two frame-buffer writers
// and two readers, with per-channel double-buffered frame addressing.
module ddr_4ch_arbiter #(
    parameter int unsigned       BURST_LEN   = 64,
    parameter int unsigned       FRAME_WORDS = 393216,
    parameter int unsigned       ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] CH0_BASE    = '0,
    parameter logic [ADDR_W-1:0] CH1_BASE    = 24'h100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ddr_init_done,
    input  logic [3:0]        req_in,
    input  logic              vin1_fs,
    input  logic              vin2_fs,
    input  logic              vout_fs,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    input  logic              cmd_done,
    output logic [3:0]        grant,
    output logic [1:0]        wr_frame_done
);

    localparam int unsigned OFF_W  = 20;
    localparam int unsigned OFFX_W = OFF_W + 1;
    localparam logic [OFFX_W-1:0] BURST_INC = OFFX_W'(BURST_LEN);
    localparam logic [OFFX_W-1:0] FRAME_CMP = OFFX_W'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               rr_last, rr_last_d;
    logic [3:0][OFF_W-1:0]    offset, offset_d;
    logic [3:0][OFFX_W-1:0]   off_inc;
    logic [3:0]               off_full;
    logic [3:0]               pend, pend_d;
    logic [1:0]               wr_bank, wr_bank_d;
    logic [1:0]               last_done_bank, last_done_bank_d;
    logic [1:0]               rd_bank, rd_bank_d;
    logic [1:0]               rd_full, rd_full_d;
    logic [1:0]               wr_frame_done_d;
    logic                     cmd_valid_d, cmd_wr_d;
    logic [ADDR_W-1:0]        cmd_addr_d, win_addr;
    logic [3:0]               grant_d;

    logic [3:0] elig, fs_vec, fs_now, own_done, own_busy, apply_fs, apply_inc;
    logic [1:0] win_idx, cand, busy_idx;
    logic       win_found, win_bank, launch, done_evt, busy_any;

    assign cmd_len = 8'(BURST_LEN);

    assign elig     = req_in & ~{rd_full, wr_frame_done};
    assign launch   = (state_q == IDLE) && ddr_init_done && win_found;
    assign done_evt = (state_q == WAIT) && cmd_done;

    // A channel counts as busy from the cycle it wins until its cmd_done.
    assign busy_any = launch || (state_q != IDLE);
    assign busy_idx = launch ? win_idx : rr_last;
    assign own_busy = busy_any ? (4'b0001 << busy_idx) : 4'b0000;
    assign own_done = done_evt ? (4'b0001 << rr_last) : 4'b0000;

    // Frame starts hit idle channels at once; busy ones wait for their cmd_done.
    assign fs_vec    = {vout_fs, vout_fs, vin2_fs, vin1_fs};
    assign fs_now    = fs_vec | pend;
    assign apply_fs  = (own_done & fs_now) | (~own_busy & fs_vec);
    assign apply_inc = own_done & ~fs_now;
    assign pend_d    = own_busy & ~own_done & fs_now;

    // Round-robin search starting after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_last;
        cand      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = 2'(rr_last + 2'(i));
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_bank = win_idx[1] ? rd_bank[win_idx[0]] : wr_bank[win_idx[0]];
        win_addr = (win_idx[0] ? CH1_BASE : CH0_BASE)
                 + (win_bank ? ADDR_W'(FRAME_WORDS) : ADDR_W'(0))
                 + ADDR_W'(offset[win_idx]);
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last;
        cmd_valid_d = cmd_valid;
        cmd_wr_d    = cmd_wr;
        cmd_addr_d  = cmd_addr;
        grant_d     = grant;
        case (state_q)
            IDLE: begin
                cmd_valid_d = 1'b0;
                grant_d     = 4'b0000;
                if (launch) begin
                    state_d     = CMD;
                    rr_last_d   = win_idx;
                    cmd_valid_d = 1'b1;
                    cmd_wr_d    = ~win_idx[1];
                    cmd_addr_d  = win_addr;
                    grant_d     = 4'b0001 << win_idx;
                end
            end
            CMD: begin
                if (cmd_ready) begin
                    state_d     = WAIT;
                    cmd_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (cmd_done) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_valid_d = 1'b0;
                grant_d     = 4'b0000;
            end
        endcase
    end

    // Offset, bank and frame-full bookkeeping.
    always_comb begin
        offset_d         = offset;
        wr_bank_d        = wr_bank;
        last_done_bank_d = last_done_bank;
        rd_bank_d        = rd_bank;
        rd_full_d        = rd_full;
        wr_frame_done_d  = wr_frame_done;
        off_inc          = '0;
        off_full         = '0;
        for (int k = 0; k < 4; k++) begin
            off_inc[k]  = {1'b0, offset[k]} + BURST_INC;
            off_full[k] = (off_inc[k] >= FRAME_CMP);
            if (apply_fs[k]) begin
                offset_d[k] = '0;
            end else if (apply_inc[k]) begin
                offset_d[k] = off_inc[k][OFF_W-1:0];
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (apply_fs[c]) begin
                wr_frame_done_d[c] = 1'b0;
                wr_bank_d[c]       = ~wr_bank[c];
            end else if (apply_inc[c] && off_full[c]) begin
                wr_frame_done_d[c]  = 1'b1;
                last_done_bank_d[c] = wr_bank[c];
            end
            if (apply_fs[c+2]) begin
                rd_full_d[c] = 1'b0;
                rd_bank_d[c] = last_done_bank[c];
            end else if (apply_inc[c+2] && off_full[c+2]) begin
                rd_full_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rr_last        <= 2'd3;
            offset         <= '0;
            pend           <= '0;
            wr_bank        <= 2'b00;
            last_done_bank <= 2'b11;
            rd_bank        <= 2'b11;
            rd_full        <= 2'b00;
            wr_frame_done  <= 2'b00;
            cmd_valid      <= 1'b0;
            cmd_wr         <= 1'b0;
            cmd_addr       <= '0;
            grant          <= 4'b0000;
        end else begin
            state_q        <= state_d;
            rr_last        <= rr_last_d;
            offset         <= offset_d;
            pend           <= pend_d;
            wr_bank        <= wr_bank_d;
            last_done_bank <= last_done_bank_d;
            rd_bank        <= rd_bank_d;
            rd_full        <= rd_full_d;
            wr_frame_done  <= wr_frame_done_d;
            cmd_valid      <= cmd_valid_d;
            cmd_wr         <= cmd_wr_d;
            cmd_addr       <= cmd_addr_d;
            grant          <= grant_d;
        end
    end

endmodule
